// File: rtl/serial_pkg.sv
// serial_pkg: word-width and timeout defaults shared by the serializer and deserializer stages.
package serial_pkg;
  localparam int default_width = 8;
  localparam int default_timeout = 16;
endpackage

// File: rtl/serial_to_parallel_buffered_if.sv
// serial_to_parallel_buffered_if: serial input, valid/ready word output and status of the deserializer.
interface serial_to_parallel_buffered_if #(parameter int width = serial_pkg::default_width);
  logic serial_valid;
  logic serial_data;
  logic parallel_valid;
  logic parallel_ready;
  logic [width-1:0] parallel_data;
  logic busy;
  logic overrun;
  modport master(
    output serial_valid, serial_data, parallel_ready,
    input parallel_valid, parallel_data, busy, overrun
  );
  modport slave(
    input serial_valid, serial_data, parallel_ready,
    output parallel_valid, parallel_data, busy, overrun
  );
endinterface

// File: rtl/serial_to_parallel_buffered_valid_ready_reg.sv
// valid_ready_reg: single-entry output register; loads a completed word when empty or draining, else drops it and pulses overrun.
module valid_ready_reg #(
  parameter int width = serial_pkg::default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] q,
  output logic             overrun
);
  always_ff @(posedge clk)
    if (rst) begin
      valid   <= 1'b0;
      q       <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && valid && !ready;
      if (load && (!valid || ready)) begin
        valid <= 1'b1;
        q     <= data;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
endmodule

// File: rtl/serial_to_parallel_buffered.sv
// serial_to_parallel_buffered: LSB-first deserializer with registered valid/ready output.
// Define SERIAL_TO_PARALLEL_TIMEOUT_EN to discard partial words idle for `timeout` cycles.
module serial_to_parallel_buffered
  import serial_pkg::*;
#(
  parameter int width = default_width,
  parameter int timeout = default_timeout
) (
  input logic clk,
  input logic rst,
  serial_to_parallel_buffered_if.slave bus
);
  localparam int cw = $clog2(width);
  logic [cw-1:0] count;
  logic [width-1:0] shift;
  logic [width-1:0] word;
  logic done;
  logic expire;
  if (width < 2 || timeout < 1) begin : g_bad_params
    $error("serial_to_parallel_buffered: width must be >= 2 and timeout >= 1");
  end
  assign done = bus.serial_valid && count == cw'(width - 1);
  assign bus.busy = count != '0;
  // the last bit bypasses the shift register so the word loads on the same edge
  always_comb begin
    word = shift;
    word[count] = bus.serial_data;
  end
  always_ff @(posedge clk)
    if (rst || expire) begin
      count <= '0;
      shift <= '0;
    end else if (bus.serial_valid) begin
      count <= done ? '0 : count + 1'b1;
      shift <= word;
    end
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
  localparam int iw = $clog2(timeout + 1);
  logic [iw-1:0] idle;
  assign expire = bus.busy && !bus.serial_valid && idle == iw'(timeout - 1);
  always_ff @(posedge clk)
    idle <= (rst || expire || bus.serial_valid || !bus.busy) ? '0 : idle + 1'b1;
`else
  assign expire = 1'b0;
`endif
  valid_ready_reg #(.width(width)) u_out (
    .clk(clk),
    .rst(rst),
    .load(done),
    .data(word),
    .ready(bus.parallel_ready),
    .valid(bus.parallel_valid),
    .q(bus.parallel_data),
    .overrun(bus.overrun)
  );
endmodule

// File: tb/tb_serial_to_parallel_buffered.sv
// tb_serial_to_parallel_buffered: scoreboard bench with a word-level reference model.
module tb_serial_to_parallel_buffered;
  localparam int W = 8;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  serial_to_parallel_buffered_if #(.width(W)) bus ();
  serial_to_parallel_buffered #(.width(W), .timeout(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  logic [W-1:0] expq[$];
  logic [W-1:0] acc = '0;
  int nbits = 0;
  int idle = 0;
  bit held = 0;
  bit exp_ov = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // reference model: one call per clock edge with the inputs that were presented
  task automatic model(input logic v, input logic d, input logic r, input logic rs);
    bit complete;
    complete = 0;
    exp_ov = 0;
    if (rs) begin
      nbits = 0;
      idle = 0;
      held = 0;
      expq.delete();
      return;
    end
    if (v) begin
      acc[nbits] = d;
      nbits++;
      idle = 0;
      if (nbits == W) begin
        complete = 1;
        nbits = 0;
      end
    end else if (nbits != 0) begin
      idle++;
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
      if (idle == TO) begin
        nbits = 0;
        idle = 0;
      end
`endif
    end
    if (complete) begin
      if (held && !r) exp_ov = 1;
      else begin
        expq.push_back(acc);
        held = 1;
      end
    end else if (held && r) held = 0;
  endtask

  task automatic step(input logic v, input logic d, input logic r, input logic rs = 1'b0);
    rst = rs;
    bus.serial_valid = v;
    bus.serial_data = d;
    bus.parallel_ready = r;
    @(posedge clk);
    model(v, d, r, rs);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input int gmin, input int gmax, input logic r);
    for (int i = 0; i < W; i++) begin
      if (i > 0) repeat ($urandom_range(gmax, gmin)) step(1'b0, 1'($urandom), r);
      step(1'b1, w[i], r);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset_outputs", {bus.parallel_valid, bus.parallel_data, bus.busy, bus.overrun}, '0);
  endtask

  // monitor: compares DUT outputs with the model between edges
  always @(negedge clk)
    if (!rst) begin
      chk("parallel_valid", bus.parallel_valid, held);
      chk("busy", bus.busy, nbits != 0);
      chk("overrun", bus.overrun, exp_ov);
      if (bus.parallel_valid) begin
        if (expq.size() == 0) chk("unexpected_word", bus.parallel_data, 'x);
        else begin
          chk("parallel_data", bus.parallel_data, expq[0]);
          if (bus.parallel_ready) void'(expq.pop_front());
        end
      end
    end

  initial begin
    bus.serial_valid = 1'b0;
    bus.serial_data = 1'b0;
    bus.parallel_ready = 1'b0;
    do_reset();
    send(8'hA5, 0, 0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    send(8'h3C, 1, 5, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    send(8'h11, 0, 0, 1'b0);
    send(8'h22, 0, 2, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    send(8'h01, 0, 0, 1'b1);
    send(8'hFE, 0, 0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    do_reset();
    send(8'h0F, 0, 0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    repeat (TO) step(1'b0, 1'b0, 1'b1);
    send(8'h5A, 0, 0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(3) != 0));
    repeat (4) step(1'b0, 1'b0, 1'b1);
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel_buffered.md
Name: serial_to_parallel_buffered

Overview:
- Deserializer placed directly downstream of the parallel-to-serial stage.
- Collects `width` serial bits, LSB first, qualified by `serial_valid`, into one word.
- Presents the word on a registered valid/ready output port.
- The serial side has no backpressure; a completed word that cannot be stored is dropped and flagged.

Parameters:
- width, 8, word width in bits; must be >= 2.
- timeout, 16, idle cycles allowed inside a partial word before it is discarded; used only with the optional feature; must be >= 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_valid  input  1  `serial_data` carries a valid bit this cycle.
- serial_data  input  1  serial bit, LSB of the word first.
- parallel_valid  output  1  output register holds a word.
- parallel_data  output  width  assembled word; stable while `parallel_valid` is high and `parallel_ready` is low.
- parallel_ready  input  1  consumer accepts the word when high together with `parallel_valid`.
- busy  output  1  partial word in progress (bit count != 0).
- overrun  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset values: `parallel_valid`=0, `parallel_data`=0, `busy`=0, `overrun`=0. Bit counter, shift register and idle counter are cleared.
- Reset mid-word discards the partial bits. Reset with a word pending discards the word.
- Bit counter: width $clog2(width), counts accepted bits. Each cycle with `serial_valid`=1, the bit is written at position `count` and the counter increments. When `count`==width-1 the counter wraps to 0 and the word is complete.
- `serial_valid`=0 holds the counter and partial bits unchanged. Gaps of any length are legal unless the optional feature is enabled.
- Latency: a word completed by the bit accepted at edge N appears with `parallel_valid`=1 from edge N (visible the cycle after the last bit). Full word = captured bits plus the last bit, merged combinationally at load.
- Output register is a single-entry valid/ready stage:
  - Handshake occurs on `parallel_valid` & `parallel_ready`. With no new word, `parallel_valid` falls the next cycle.
  - A completed word in a cycle with `parallel_valid`=0 is loaded.
  - A completed word in the same cycle as a handshake is loaded: `parallel_valid` stays high with the new data (back-to-back, no bubble).
  - A completed word while `parallel_valid`=1 and `parallel_ready`=0 is dropped. The held word is kept unchanged and `overrun` pulses high for exactly one cycle.
- `busy` = (count != 0); registered state, no combinational path from inputs.
- `parallel_ready` is not required to be stable and has no effect while `parallel_valid`=0.
- The next word's first bit may arrive in the cycle right after the previous word's last bit; the counter is already 0.

Optional Feature:
- Macro: SERIAL_TO_PARALLEL_TIMEOUT_EN.
- Defined:
  - An idle counter counts consecutive cycles with `busy`=1 and `serial_valid`=0. It resets on any accepted bit.
  - When it reaches `timeout`, the bit counter and partial bits are cleared on that edge and `busy` drops.
  - No word is output and `overrun` is not asserted.
- Undefined: no idle counter; partial words are held indefinitely; the `timeout` parameter is unused.

Decomposition:
- Shared package serial_pkg:
  - default word-width constant, shared with the parallel-to-serial stage;
  - default timeout constant.
- Counter widths are derived locally with $clog2 from the parameters.
- One natural sub-module, valid_ready_reg: single-entry output register with load/drop decision and overrun pulse, parameterized by width.
- Bit collection, counter and timeout logic stay in the top module.

Test Plan:
- width=8; reset, then 8 consecutive valid bits for 0xA5 (LSB first: 1,0,1,0,0,1,0,1) with `parallel_ready`=1 -> `parallel_valid`=1 for one cycle with `parallel_data`=0xA5. `busy` is high after the first bit and low after the 8th.
- Bits of 0x3C with `serial_valid` gaps of 1-5 cycles between bits -> `parallel_data`=0x3C; `busy` holds high through the gaps.
- `parallel_ready`=0 and word 0x11 pending, then word 0x22 completes -> `overrun` pulses once; `parallel_data` stays 0x11. After `parallel_ready`=1, the 0x11 handshake occurs and 0x22 never appears.
- Back-to-back words 0x01 then 0xFE with `parallel_ready`=1 and no serial gap -> consecutive valid outputs 0x01 then 0xFE, no bubble, `overrun`=0.
- Assert `rst` after 4 bits of 0xFF, then send 0x0F -> output is 0x0F (no stale bits); all outputs are 0 during reset.
- With SERIAL_TO_PARALLEL_TIMEOUT_EN and timeout=16: 3 bits, 16 idle cycles, then 8 bits of 0x5A -> `busy` drops after the 16th idle cycle; the only output is 0x5A; `overrun`=0.
